// File: rtl/simon_pkg.sv
// Shared definitions for the parameterised SIMON core.
//   word_t     : 64-bit container; helpers operate on the low n bits only
//   state_e    : controller states
//   Z_SEQ      : the five 62-bit z sequences, Z_SEQ[j][61] is z_j bit 0
//   rol/ror/f  : n-bit rotations and the SIMON round function
//   std_rounds/std_z : standard (N, M) -> (T, Z) table, 0 / 5 for illegal pairs
package simon_pkg;

  typedef logic [63:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEXP,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [4:0][61:0] Z_SEQ = {
    62'b11010001111001101011011000100000010111000011001010010011101111,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b11111010001001010110000111001101111101000100101011000011100110
  };

  function automatic word_t width_mask(input int unsigned n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic word_t rol(input word_t v, input int unsigned s, input int unsigned n);
    word_t m;
    word_t vm;
    m  = width_mask(n);
    vm = v & m;
    return ((vm << s) | (vm >> (n - s))) & m;
  endfunction

  function automatic word_t ror(input word_t v, input int unsigned s, input int unsigned n);
    return rol(v, n - s, n);
  endfunction

  function automatic word_t f(input word_t v, input int unsigned n);
    return (rol(v, 1, n) & rol(v, 8, n)) ^ rol(v, 2, n);
  endfunction

  function automatic int unsigned std_rounds(input int unsigned n, input int unsigned m);
    int unsigned t;
    t = 0;
    case ({n[7:0], m[7:0]})
      {8'd16, 8'd4}: t = 32;
      {8'd24, 8'd3}: t = 36;
      {8'd24, 8'd4}: t = 36;
      {8'd32, 8'd3}: t = 42;
      {8'd32, 8'd4}: t = 44;
      {8'd48, 8'd2}: t = 52;
      {8'd48, 8'd3}: t = 54;
      {8'd64, 8'd2}: t = 68;
      {8'd64, 8'd3}: t = 69;
      {8'd64, 8'd4}: t = 72;
      default:       t = 0;
    endcase
    return t;
  endfunction

  function automatic int unsigned std_z(input int unsigned n, input int unsigned m);
    int unsigned z;
    z = 5;
    case ({n[7:0], m[7:0]})
      {8'd16, 8'd4}: z = 0;
      {8'd24, 8'd3}: z = 0;
      {8'd24, 8'd4}: z = 1;
      {8'd32, 8'd3}: z = 2;
      {8'd32, 8'd4}: z = 3;
      {8'd48, 8'd2}: z = 2;
      {8'd48, 8'd3}: z = 3;
      {8'd64, 8'd2}: z = 2;
      {8'd64, 8'd3}: z = 3;
      {8'd64, 8'd4}: z = 4;
      default:       z = 5;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/simon_key_store.sv
// Round-key register file and key-expansion datapath.
//   clk    : clock
//   load   : capture key[0..M-1] into k[0..M-1]
//   key    : packed key words, key[0] = k0
//   expand : write k[idx] from the expansion recurrence
//   idx    : index of the round key being generated (M..T-1)
//   rd_cnt : round counter
//   rd_rev : 1 selects k[T-1-rd_cnt] (decrypt), 0 selects k[rd_cnt]
//   rk     : selected round key (0 when the index is out of range)
module simon_key_store
  import simon_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned M  = 3,
  parameter int unsigned T  = 42,
  parameter int unsigned Z  = 2,
  parameter int unsigned Co = 6
) (
  input  logic                clk,
  input  logic                load,
  input  logic [M-1:0][N-1:0] key,
  input  logic                expand,
  input  logic [Co-1:0]       idx,
  input  logic [Co-1:0]       rd_cnt,
  input  logic                rd_rev,
  output logic [N-1:0]        rk
);

  logic [N-1:0]  k_q [T];
  logic [N-1:0]  k_d [T];
  logic [Co-1:0] idx_m1;
  logic [Co-1:0] idx_m3;
  logic [Co-1:0] idx_mm;
  logic [Co-1:0] zj;
  logic [Co-1:0] rd_idx;
  logic [N-1:0]  prev1;
  logic [N-1:0]  prev3;
  logic [N-1:0]  prevm;
  logic [N-1:0]  new_k;
  logic [61:0]   z_row;
  logic          z_bit;
  word_t         tmp;

  always_comb begin
    idx_m1 = idx - Co'(1);
    idx_m3 = idx - Co'(3);
    idx_mm = idx - Co'(M);
    zj     = (idx_mm >= Co'(62)) ? idx_mm - Co'(62) : idx_mm;
    rd_idx = rd_rev ? Co'(T - 1) - rd_cnt : rd_cnt;

    // Explicit compare-and-select muxes keep every array access in range.
    prev1 = '0;
    prev3 = '0;
    prevm = '0;
    rk    = '0;
    for (int unsigned e = 0; e < T; e++) begin
      if (idx_m1 == Co'(e)) prev1 = k_q[e];
      if (idx_m3 == Co'(e)) prev3 = k_q[e];
      if (idx_mm == Co'(e)) prevm = k_q[e];
      if (rd_idx == Co'(e)) rk    = k_q[e];
    end

    z_row = Z_SEQ[Z];
    z_bit = z_row[6'd61 - zj[5:0]];

    tmp = ror(word_t'(prev1), 3, N);
    if (M == 4) tmp = tmp ^ word_t'(prev3);
    tmp   = tmp ^ ror(tmp, 1, N);
    new_k = ~prevm ^ N'(tmp) ^ {{(N-1){1'b0}}, z_bit} ^ N'(3);

    k_d = k_q;
    if (load) begin
      for (int unsigned e = 0; e < M; e++) k_d[e] = key[e];
    end
    if (expand) begin
      for (int unsigned e = 0; e < T; e++) begin
        if (idx == Co'(e)) k_d[e] = new_k;
      end
    end
  end

  always_ff @(posedge clk) begin
    k_q <= k_d;
  end

endmodule

// File: rtl/simon_param_core.sv
// Iterative SIMON 2N/MN block cipher, one round per clock, stored key schedule.
//   clk, nR           : clock, synchronous active-low reset
//   newData, newKey   : level requests to load a block / a key
//   enc_dec           : 1 encrypt, 0 decrypt (sampled at block accept)
//   readData          : consumer acknowledge of cipher
//   plain             : input block {x, y}
//   key               : packed key words, key[0] = k0
//   ldData, ldKey     : one-cycle accept pulses
//   doneData          : cipher valid until readData
//   doneKey           : round-key schedule valid
//   cipher            : result block {x, y}
module simon_param_core
  import simon_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned M  = 3,
  parameter int unsigned T  = 42,
  parameter int unsigned Co = 6,
  parameter int unsigned Z  = 2
) (
  input  logic                clk,
  input  logic                nR,
  input  logic                newData,
  input  logic                newKey,
  input  logic                enc_dec,
  input  logic                readData,
  input  logic [2*N-1:0]      plain,
  input  logic [M-1:0][N-1:0] key,
  output logic                ldData,
  output logic                ldKey,
  output logic                doneData,
  output logic                doneKey,
  output logic [2*N-1:0]      cipher
);

  if (std_rounds(N, M) != T || std_z(N, M) != Z || (2 ** Co) <= T) begin : g_bad_cfg
    $error("simon_param_core: illegal N/M/T/Z/Co combination");
  end

  state_e         state_q, state_d;
  logic [Co-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   y_q, y_d;
  logic           enc_q, enc_d;
  logic [2*N-1:0] cipher_q, cipher_d;
  logic           ld_data_q, ld_data_d;
  logic           ld_key_q, ld_key_d;
  logic           done_data_q, done_data_d;
  logic           done_key_q, done_key_d;
  logic           ks_load;
  logic           ks_expand;
  logic [N-1:0]   rk;

  simon_key_store #(
    .N  (N),
    .M  (M),
    .T  (T),
    .Z  (Z),
    .Co (Co)
  ) u_key_store (
    .clk    (clk),
    .load   (ks_load),
    .key    (key),
    .expand (ks_expand),
    .idx    (cnt_q),
    .rd_cnt (cnt_q),
    .rd_rev (~enc_q),
    .rk     (rk)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    enc_d       = enc_q;
    cipher_d    = cipher_q;
    ld_data_d   = 1'b0;
    ld_key_d    = 1'b0;
    done_data_d = done_data_q;
    done_key_d  = done_key_q;
    ks_load     = 1'b0;
    ks_expand   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (newKey) begin
          ks_load    = 1'b1;
          ld_key_d   = 1'b1;
          done_key_d = 1'b0;
          cnt_d      = Co'(M);
          state_d    = ST_KEXP;
        end else if (newData && done_key_q) begin
          x_d       = plain[2*N-1:N];
          y_d       = plain[N-1:0];
          enc_d     = enc_dec;
          ld_data_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RUN;
        end
      end

      ST_KEXP: begin
        ks_expand = 1'b1;
        if (cnt_q == Co'(T - 1)) begin
          done_key_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + Co'(1);
        end
      end

      ST_RUN: begin
        // Rounds run at cnt 0..T-1; the cnt == T cycle only publishes the
        // result, giving doneData T+1 cycles after ldData.
        if (cnt_q == Co'(T)) begin
          cipher_d    = {x_q, y_q};
          done_data_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          if (enc_q) begin
            x_d = y_q ^ N'(f(word_t'(x_q), N)) ^ rk;
            y_d = x_q;
          end else begin
            x_d = y_q;
            y_d = x_q ^ N'(f(word_t'(y_q), N)) ^ rk;
          end
          cnt_d = cnt_q + Co'(1);
        end
      end

      ST_DONE: begin
        if (readData) begin
          done_data_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nR) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      enc_q       <= 1'b0;
      cipher_q    <= '0;
      ld_data_q   <= 1'b0;
      ld_key_q    <= 1'b0;
      done_data_q <= 1'b0;
      done_key_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      enc_q       <= enc_d;
      cipher_q    <= cipher_d;
      ld_data_q   <= ld_data_d;
      ld_key_q    <= ld_key_d;
      done_data_q <= done_data_d;
      done_key_q  <= done_key_d;
    end
  end

  assign ldData   = ld_data_q;
  assign ldKey    = ld_key_q;
  assign doneData = done_data_q;
  assign doneKey  = done_key_q;
  assign cipher   = cipher_q;

endmodule

// File: tb/tb_simon_param_core.sv
// Directed bench for simon_param_core: SIMON 64/96, 32/64 and 128/128 instances.
module tb_simon_param_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [95:0] KEY_A = 96'h13121110_0b0a0908_03020100;
  localparam logic [63:0] PT_A  = 64'h6f7220676e696c63;
  localparam logic [63:0] CT_A  = 64'h5ca2e27f111a8fc8;

  // 64/96 instance
  logic            a_nr, a_new_data, a_new_key, a_enc, a_read;
  logic [63:0]     a_plain;
  logic [2:0][31:0] a_key;
  logic            a_ld_data, a_ld_key, a_done_data, a_done_key;
  logic [63:0]     a_cipher;

  simon_param_core #(.N(32), .M(3), .T(42), .Co(6), .Z(2)) u_a (
    .clk(clk), .nR(a_nr), .newData(a_new_data), .newKey(a_new_key),
    .enc_dec(a_enc), .readData(a_read), .plain(a_plain), .key(a_key),
    .ldData(a_ld_data), .ldKey(a_ld_key), .doneData(a_done_data),
    .doneKey(a_done_key), .cipher(a_cipher)
  );

  // 32/64 instance
  logic            b_nr, b_new_data, b_new_key, b_enc, b_read;
  logic [31:0]     b_plain;
  logic [3:0][15:0] b_key;
  logic            b_ld_data, b_ld_key, b_done_data, b_done_key;
  logic [31:0]     b_cipher;

  simon_param_core #(.N(16), .M(4), .T(32), .Co(6), .Z(0)) u_b (
    .clk(clk), .nR(b_nr), .newData(b_new_data), .newKey(b_new_key),
    .enc_dec(b_enc), .readData(b_read), .plain(b_plain), .key(b_key),
    .ldData(b_ld_data), .ldKey(b_ld_key), .doneData(b_done_data),
    .doneKey(b_done_key), .cipher(b_cipher)
  );

  // 128/128 instance
  logic            c_nr, c_new_data, c_new_key, c_enc, c_read;
  logic [127:0]    c_plain;
  logic [1:0][63:0] c_key;
  logic            c_ld_data, c_ld_key, c_done_data, c_done_key;
  logic [127:0]    c_cipher;

  simon_param_core #(.N(64), .M(2), .T(68), .Co(7), .Z(2)) u_c (
    .clk(clk), .nR(c_nr), .newData(c_new_data), .newKey(c_new_key),
    .enc_dec(c_enc), .readData(c_read), .plain(c_plain), .key(c_key),
    .ldData(c_ld_data), .ldKey(c_ld_key), .doneData(c_done_data),
    .doneKey(c_done_key), .cipher(c_cipher)
  );

  // Accept-pulse monitors for the 64/96 instance
  int a_ld_seen = 0;
  int a_early   = 0;
  always @(negedge clk) begin
    if (a_ld_data) a_ld_seen++;
    if (a_ld_data && !a_done_key) a_early++;
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_load_key(input string tag);
    int n;
    a_key = KEY_A;
    a_new_key = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_ld_key && n < 10);
    check1({tag, "_ldkey"}, a_ld_key, 1'b1);
    a_new_key = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_done_key && n < 100);
    checkv({tag, "_kexp_cycles"}, 128'(n), 128'(39));
  endtask

  task automatic a_block(input logic [63:0] pt, input logic enc, input logic [63:0] exp,
                         input string tag);
    int n;
    a_plain = pt;
    a_enc = enc;
    a_new_data = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_ld_data && n < 100);
    check1({tag, "_ld"}, a_ld_data, 1'b1);
    a_new_data = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_done_data && n < 200);
    checkv({tag, "_latency"}, 128'(n), 128'(43));
    checkv({tag, "_cipher"}, 128'(a_cipher), 128'(exp));
    repeat (2) @(negedge clk);
    a_read = 1'b1;
    @(negedge clk);
    a_read = 1'b0;
    check1({tag, "_ack_drop"}, a_done_data, 1'b0);
  endtask

  initial begin
    int n;
    int base;
    logic stable;

    a_nr = 1'b0; a_new_data = 1'b0; a_new_key = 1'b0; a_enc = 1'b1; a_read = 1'b0;
    a_plain = '0; a_key = '0;
    b_nr = 1'b0; b_new_data = 1'b0; b_new_key = 1'b0; b_enc = 1'b1; b_read = 1'b0;
    b_plain = '0; b_key = '0;
    c_nr = 1'b0; c_new_data = 1'b0; c_new_key = 1'b0; c_enc = 1'b1; c_read = 1'b0;
    c_plain = '0; c_key = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkv("reset_outputs", 128'({a_ld_data, a_ld_key, a_done_data, a_done_key, a_cipher}), '0);
    a_nr = 1'b1; b_nr = 1'b1; c_nr = 1'b1;

    // newKey and newData together: key first, block after schedule is ready
    a_key = KEY_A; a_plain = PT_A; a_enc = 1'b1;
    a_new_key = 1'b1; a_new_data = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_ld_key && n < 10);
    check1("hs_ldkey", a_ld_key, 1'b1);
    check1("hs_no_lddata_with_ldkey", a_ld_data, 1'b0);
    a_new_key = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_ld_data && n < 100);
    check1("hs_lddata", a_ld_data, 1'b1);
    checkv("hs_accept_delay", 128'(n), 128'(40));
    check1("hs_donekey_at_accept", a_done_key, 1'b1);
    checkv("hs_early_accepts", 128'(a_early), 128'(0));
    a_new_data = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_done_data && n < 200);
    checkv("enc_latency", 128'(n), 128'(43));
    checkv("enc_cipher", 128'(a_cipher), 128'(CT_A));

    // Hold in DONE with readData low and a stray newData
    a_plain = CT_A; a_enc = 1'b0; a_new_data = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!a_done_data || a_cipher !== CT_A || a_ld_data) stable = 1'b0;
    end
    check1("hold_stable", stable, 1'b1);
    checkv("hold_no_accept", 128'(a_ld_seen), 128'(1));
    a_new_data = 1'b0;
    a_read = 1'b1;
    @(negedge clk);
    a_read = 1'b0;
    check1("hold_ack_drop", a_done_data, 1'b0);

    // Decrypt
    a_block(CT_A, 1'b0, PT_A, "dec");

    // Stream of five blocks
    base = a_ld_seen;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) a_block(PT_A, 1'b1, CT_A, "stream_enc");
      else            a_block(CT_A, 1'b0, PT_A, "stream_dec");
    end
    checkv("stream_accepts", 128'(a_ld_seen - base), 128'(5));

    // Reset at round 20
    a_plain = PT_A; a_enc = 1'b1; a_new_data = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_ld_data && n < 100);
    check1("rrun_ld", a_ld_data, 1'b1);
    a_new_data = 1'b0;
    repeat (20) @(negedge clk);
    a_nr = 1'b0;
    @(negedge clk);
    checkv("rst_run_outputs", 128'({a_ld_data, a_ld_key, a_done_data, a_done_key, a_cipher}), '0);
    a_nr = 1'b1;
    base = a_ld_seen;
    a_new_data = 1'b1;
    repeat (10) @(negedge clk);
    checkv("rst_run_no_accept", 128'(a_ld_seen - base), 128'(0));
    a_load_key("reload");
    a_block(PT_A, 1'b1, CT_A, "reload");

    // Reset during key expansion
    a_new_key = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_ld_key && n < 10);
    check1("rkexp_ldkey", a_ld_key, 1'b1);
    a_new_key = 1'b0;
    repeat (10) @(negedge clk);
    a_nr = 1'b0;
    @(negedge clk);
    checkv("rst_kexp_outputs", 128'({a_ld_data, a_ld_key, a_done_data, a_done_key, a_cipher}), '0);
    a_nr = 1'b1;
    base = a_ld_seen;
    a_plain = PT_A; a_enc = 1'b1; a_new_data = 1'b1;
    repeat (8) @(negedge clk);
    checkv("rst_kexp_no_accept", 128'(a_ld_seen - base), 128'(0));
    a_new_data = 1'b0;
    a_load_key("reload2");
    a_block(CT_A, 1'b0, PT_A, "reload2");

    // SIMON 32/64
    b_key = 64'h1918_1110_0908_0100;
    b_new_key = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_ld_key && n < 10);
    check1("b_ldkey", b_ld_key, 1'b1);
    b_new_key = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_done_key && n < 100);
    checkv("b_kexp_cycles", 128'(n), 128'(28));
    b_plain = 32'h65656877; b_enc = 1'b1; b_new_data = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_ld_data && n < 10);
    check1("b_ld", b_ld_data, 1'b1);
    b_new_data = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_done_data && n < 200);
    checkv("b_latency", 128'(n), 128'(33));
    checkv("b_cipher", 128'(b_cipher), 128'(32'hc69be9bb));
    b_read = 1'b1;
    @(negedge clk);
    b_read = 1'b0;
    b_plain = 32'hc69be9bb; b_enc = 1'b0; b_new_data = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_ld_data && n < 10);
    b_new_data = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_done_data && n < 200);
    checkv("b_dec_plain", 128'(b_cipher), 128'(32'h65656877));
    b_read = 1'b1;
    @(negedge clk);
    b_read = 1'b0;

    // SIMON 128/128
    c_key = 128'h0f0e0d0c0b0a0908_0706050403020100;
    c_new_key = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!c_ld_key && n < 10);
    check1("c_ldkey", c_ld_key, 1'b1);
    c_new_key = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!c_done_key && n < 100);
    checkv("c_kexp_cycles", 128'(n), 128'(66));
    c_plain = 128'h63736564207372656c6c657661727420; c_enc = 1'b1; c_new_data = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!c_ld_data && n < 10);
    check1("c_ld", c_ld_data, 1'b1);
    c_new_data = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!c_done_data && n < 200);
    checkv("c_latency", 128'(n), 128'(69));
    checkv("c_cipher", c_cipher, 128'h49681b1e1e54fe3f65aa832af84e0bbc);
    c_read = 1'b1;
    @(negedge clk);
    c_read = 1'b0;
    c_plain = 128'h49681b1e1e54fe3f65aa832af84e0bbc; c_enc = 1'b0; c_new_data = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!c_ld_data && n < 10);
    c_new_data = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!c_done_data && n < 200);
    checkv("c_dec_plain", c_cipher, 128'h63736564207372656c6c657661727420);
    c_read = 1'b1;
    @(negedge clk);
    c_read = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
